// File: rtl/neuron_layer_driver.sv
// Layer driver for a serial neuron MAC: holds the per-row table, walks the enabled
// rows for one captured input vector, and streams MAC results out tagged by row.
module neuron_layer_driver #(
  parameter int unsigned NUM_INPUTS  = 8,
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned X_W         = 8,
  parameter int unsigned W_W         = 8,
  parameter int unsigned B_W         = 32,
  parameter int unsigned OUT_W       = 16,
  localparam int unsigned IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_addr,
  input  logic                        cfg_en,
  input  logic [NUM_INPUTS*W_W-1:0]   cfg_w,
  input  logic [B_W-1:0]              cfg_bias,
  input  logic [NUM_INPUTS-1:0]       cfg_mask,
  input  logic [1:0]                  cfg_act,
  input  logic                        vec_valid,
  output logic                        vec_ready,
  input  logic [NUM_INPUTS*X_W-1:0]   vec_x,
  output logic                        mac_in_valid,
  input  logic                        mac_in_ready,
  output logic [B_W-1:0]              mac_bias,
  output logic [NUM_INPUTS*X_W-1:0]   mac_x_flat,
  output logic [NUM_INPUTS*W_W-1:0]   mac_w_flat,
  output logic [1:0]                  mac_act_sel,
  output logic [NUM_INPUTS-1:0]       mac_mask_flat,
  input  logic                        mac_out_valid,
  output logic                        mac_out_ready,
  input  logic [OUT_W-1:0]            mac_out_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [OUT_W-1:0]            res_data,
  output logic [IDX_W-1:0]            res_idx,
  output logic                        res_last,
  output logic                        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT} state_e;

  state_e                      state_q;
  logic [NUM_NEURONS-1:0]      en_q;
  logic [NUM_INPUTS*W_W-1:0]   w_q    [NUM_NEURONS];
  logic [B_W-1:0]              bias_q [NUM_NEURONS];
  logic [NUM_INPUTS-1:0]       mask_q [NUM_NEURONS];
  logic [1:0]                  act_q  [NUM_NEURONS];
  logic [IDX_W-1:0]            idx_q;
  logic [NUM_INPUTS*X_W-1:0]   x_q;
  logic [B_W-1:0]              mac_bias_q;
  logic [NUM_INPUTS*W_W-1:0]   mac_w_q;
  logic [NUM_INPUTS-1:0]       mac_mask_q;
  logic [1:0]                  mac_act_q;
  logic                        mac_in_valid_q, mac_out_ready_q;
  logic                        res_valid_q, res_last_q, busy_q;
  logic [OUT_W-1:0]            res_data_q;
  logic [IDX_W-1:0]            res_idx_q;

  // Lowest enabled row at or above start; MSB is the found flag.
  function automatic logic [IDX_W:0] find_en(input logic [NUM_NEURONS-1:0] en, input int start);
    logic             found;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(NUM_NEURONS); i++) begin
      if (!found && en[i] && (i >= start)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    return {found, idx};
  endfunction

  logic [IDX_W:0]   first_r, next_r;
  logic [IDX_W-1:0] sel_idx;

  always_comb begin
    first_r = find_en(en_q, 0);
    next_r  = find_en(en_q, int'(idx_q) + 1);
    sel_idx = (state_q == S_IDLE) ? first_r[IDX_W-1:0] : next_r[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      en_q            <= '0;
      idx_q           <= '0;
      mac_in_valid_q  <= 1'b0;
      mac_out_ready_q <= 1'b0;
      res_valid_q     <= 1'b0;
      res_last_q      <= 1'b0;
      res_data_q      <= '0;
      res_idx_q       <= '0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_we) begin
            en_q[cfg_addr]   <= cfg_en;
            w_q[cfg_addr]    <= cfg_w;
            bias_q[cfg_addr] <= cfg_bias;
            mask_q[cfg_addr] <= cfg_mask;
            act_q[cfg_addr]  <= cfg_act;
          end
          if (vec_valid) begin
            x_q <= vec_x;
            if (first_r[IDX_W]) begin
              idx_q          <= sel_idx;
              mac_bias_q     <= bias_q[sel_idx];
              mac_w_q        <= w_q[sel_idx];
              mac_mask_q     <= mask_q[sel_idx];
              mac_act_q      <= act_q[sel_idx];
              mac_in_valid_q <= 1'b1;
              busy_q         <= 1'b1;
              state_q        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mac_in_ready) begin
            mac_in_valid_q  <= 1'b0;
            mac_out_ready_q <= 1'b1;
            state_q         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mac_out_valid) begin
            res_data_q      <= mac_out_data;
            res_idx_q       <= idx_q;
            res_last_q      <= ~next_r[IDX_W];
            res_valid_q     <= 1'b1;
            mac_out_ready_q <= 1'b0;
            state_q         <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (res_last_q) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              // idx_q is still the emitted row here, so next_r is the following row.
              idx_q          <= sel_idx;
              mac_bias_q     <= bias_q[sel_idx];
              mac_w_q        <= w_q[sel_idx];
              mac_mask_q     <= mask_q[sel_idx];
              mac_act_q      <= act_q[sel_idx];
              mac_in_valid_q <= 1'b1;
              state_q        <= S_ISSUE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_ready     = (state_q == S_IDLE) && !rst;
  assign mac_in_valid  = mac_in_valid_q;
  assign mac_bias      = mac_bias_q;
  assign mac_x_flat    = x_q;
  assign mac_w_flat    = mac_w_q;
  assign mac_act_sel   = mac_act_q;
  assign mac_mask_flat = mac_mask_q;
  assign mac_out_ready = mac_out_ready_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_idx       = res_idx_q;
  assign res_last      = res_last_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_neuron_layer_driver.sv
// Directed bench for neuron_layer_driver: the bench plays layer controller, MAC and
// result sink, cycle-exactly, against its own copy of the row table.
module tb_neuron_layer_driver;

  localparam int unsigned NI = 8;
  localparam int unsigned NN = 4;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [IW-1:0]   cfg_addr;
  logic            cfg_en;
  logic [63:0]     cfg_w;
  logic [31:0]     cfg_bias;
  logic [7:0]      cfg_mask;
  logic [1:0]      cfg_act;
  logic            vec_valid, vec_ready;
  logic [63:0]     vec_x;
  logic            mac_in_valid, mac_in_ready;
  logic [31:0]     mac_bias;
  logic [63:0]     mac_x_flat, mac_w_flat;
  logic [1:0]      mac_act_sel;
  logic [7:0]      mac_mask_flat;
  logic            mac_out_valid, mac_out_ready;
  logic [15:0]     mac_out_data;
  logic            res_valid, res_ready;
  logic [15:0]     res_data;
  logic [IW-1:0]   res_idx;
  logic            res_last, busy;

  int errors = 0;
  int checks = 0;

  logic        tb_en   [NN];
  logic [63:0] tb_w    [NN];
  logic [31:0] tb_bias [NN];
  logic [7:0]  tb_mask [NN];
  logic [1:0]  tb_act  [NN];

  always #5 clk = ~clk;

  neuron_layer_driver #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .X_W(8), .W_W(8), .B_W(32), .OUT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_w(cfg_w),
    .cfg_bias(cfg_bias), .cfg_mask(cfg_mask), .cfg_act(cfg_act),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_x(vec_x),
    .mac_in_valid(mac_in_valid), .mac_in_ready(mac_in_ready), .mac_bias(mac_bias),
    .mac_x_flat(mac_x_flat), .mac_w_flat(mac_w_flat), .mac_act_sel(mac_act_sel),
    .mac_mask_flat(mac_mask_flat), .mac_out_valid(mac_out_valid),
    .mac_out_ready(mac_out_ready), .mac_out_data(mac_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int row, input logic en, input logic [31:0] bias, input bit upd);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = IW'(row);
    cfg_en   = en;
    cfg_w    = 64'h10 << (row * 8);
    cfg_bias = bias;
    cfg_mask = 8'hFF ^ 8'(row);
    cfg_act  = 2'(row);
    if (upd) begin
      tb_en[row]   = en;
      tb_w[row]    = cfg_w;
      tb_bias[row] = bias;
      tb_mask[row] = cfg_mask;
      tb_act[row]  = cfg_act;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic chk_payload(input string tag, input int r, input logic [63:0] x);
    chk({tag, "_in_valid"}, 64'(mac_in_valid), 64'(1));
    chk({tag, "_bias"}, 64'(mac_bias), 64'(tb_bias[r]));
    chk({tag, "_w"}, mac_w_flat, tb_w[r]);
    chk({tag, "_x"}, mac_x_flat, x);
    chk({tag, "_mask"}, 64'(mac_mask_flat), 64'(tb_mask[r]));
    chk({tag, "_act"}, 64'(mac_act_sel), 64'(tb_act[r]));
  endtask

  task automatic chk_result(input string tag, input int r, input bit last);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(1));
    chk({tag, "_res_data"}, 64'(res_data), 64'(r * 100));
    chk({tag, "_res_idx"}, 64'(res_idx), 64'(r));
    chk({tag, "_res_last"}, 64'(res_last), 64'(last));
  endtask

  // One vector end to end; every handshake step is checked at a fixed cycle.
  task automatic do_vector(input logic [63:0] x, input int in_stall, input int res_stall,
                           input bit busy_wr);
    bit any = 1'b0;
    @(negedge clk);
    chk("vec_ready_idle", 64'(vec_ready), 64'(1));
    vec_valid = 1'b1;
    vec_x     = x;
    @(negedge clk);
    vec_valid = 1'b0;
    vec_x     = '0;
    for (int r = 0; r < int'(NN); r++) begin
      bit last = 1'b1;
      if (!tb_en[r]) continue;
      any = 1'b1;
      for (int j = r + 1; j < int'(NN); j++) if (tb_en[j]) last = 1'b0;
      chk_payload("issue", r, x);
      chk("busy_issue", 64'(busy), 64'(1));
      for (int s = 0; s < in_stall; s++) begin
        if (busy_wr && s == 0) begin
          cfg_we = 1'b1; cfg_addr = 2'd2; cfg_en = 1'b0;
          cfg_bias = 32'hBAD0_0BAD; cfg_w = '1; cfg_mask = '0; cfg_act = 2'd0;
        end
        @(negedge clk);
        cfg_we = 1'b0;
        chk_payload("stall", r, x);
      end
      mac_in_ready = 1'b1;
      @(negedge clk);
      mac_in_ready = 1'b0;
      chk("wait_in_valid", 64'(mac_in_valid), 64'(0));
      chk("wait_out_ready", 64'(mac_out_ready), 64'(1));
      mac_out_valid = 1'b1;
      mac_out_data  = 16'(r * 100);
      @(negedge clk);
      mac_out_valid = 1'b0;
      chk_result("emit", r, last);
      chk("emit_out_ready", 64'(mac_out_ready), 64'(0));
      for (int s = 0; s < res_stall; s++) begin
        @(negedge clk);
        chk_result("hold", r, last);
        chk("hold_in_valid", 64'(mac_in_valid), 64'(0));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    chk("end_res_valid", 64'(res_valid), 64'(0));
    chk("end_in_valid", 64'(mac_in_valid), 64'(0));
    chk("end_busy", 64'(busy), 64'(0));
    chk("end_vec_ready", 64'(vec_ready), 64'(1));
    if (!any) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        chk("none_in_valid", 64'(mac_in_valid), 64'(0));
        chk("none_res_valid", 64'(res_valid), 64'(0));
        chk("none_busy", 64'(busy), 64'(0));
      end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_w = '0; cfg_bias = '0;
    cfg_mask = '0; cfg_act = '0; vec_valid = 1'b0; vec_x = '0; mac_in_ready = 1'b0;
    mac_out_valid = 1'b0; mac_out_data = '0; res_ready = 1'b0;
    for (int r = 0; r < int'(NN); r++) begin
      tb_en[r] = 1'b0; tb_w[r] = '0; tb_bias[r] = '0; tb_mask[r] = '0; tb_act[r] = '0;
    end

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_valid", 64'(mac_in_valid), 64'(0));
    chk("rst_out_ready", 64'(mac_out_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_last", 64'(res_last), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_res_idx", 64'(res_idx), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_vec_ready", 64'(vec_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_vec_ready", 64'(vec_ready), 64'(1));

    // All four rows: results 0,100,200,300, last only on row 3
    for (int r = 0; r < int'(NN); r++) cfg_write(r, 1'b1, 32'h1000 + 32'(r), 1'b1);
    do_vector(64'h0102_0304_0506_0708, 0, 0, 1'b0);

    // Sparse rows 1 and 3
    cfg_write(0, 1'b0, 32'h1000, 1'b1);
    cfg_write(2, 1'b0, 32'h1002, 1'b1);
    do_vector(64'hF0E1_D2C3_B4A5_9687, 0, 0, 1'b0);

    // No enabled rows
    cfg_write(1, 1'b0, 32'h1001, 1'b1);
    cfg_write(3, 1'b0, 32'h1003, 1'b1);
    do_vector(64'h1111_2222_3333_4444, 0, 0, 1'b0);

    // Backpressure, with a row-2 write attempted while busy (must be ignored)
    for (int r = 0; r < int'(NN); r++) cfg_write(r, 1'b1, 32'h2000 + 32'(r), 1'b1);
    do_vector(64'h8081_7F7E_0001_FFFE, 5, 7, 1'b1);

    // Same row-2 write in IDLE takes effect on the next vector
    cfg_write(2, 1'b1, 32'hCAFE_0002, 1'b1);
    do_vector(64'h5A5A_A5A5_0F0F_F0F0, 1, 1, 1'b0);

    // Reset while waiting for the MAC result
    @(negedge clk);
    vec_valid = 1'b1;
    vec_x     = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    vec_valid    = 1'b0;
    mac_in_ready = 1'b1;
    @(negedge clk);
    mac_in_ready = 1'b0;
    chk("pre_rst_out_ready", 64'(mac_out_ready), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_ready", 64'(mac_out_ready), 64'(0));
    chk("abort_res_valid", 64'(res_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_in_valid", 64'(mac_in_valid), 64'(0));
    chk("abort_vec_ready", 64'(vec_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("abort_vec_ready_rel", 64'(vec_ready), 64'(1));
    for (int r = 0; r < int'(NN); r++) tb_en[r] = 1'b0;
    do_vector(64'h0F1E_2D3C_4B5A_6978, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
